pc_ras_unit: RTL

- Parametrised fetch-stage program-counter unit for the pipelined MIPS core; next generation of the existing PC register.
- Adds a configurable reset vector, an exception redirect vector and a circular return-address stack (RAS).
- The RAS predicts `jr $ra` targets in fetch.
- Drives PCF/PCPlus4F to instruction memory and the F/D pipeline register; takes stall and redirect inputs from the hazard unit and decode stage.

---
 rtl/pc_ras_unit.sv | 130 +++++++++++++
 1 files changed

// File: rtl/pc_ras_unit.sv
// ---------------------------------------------------------------------------
// pc_ras_unit
//
// Fetch-stage program counter with a configurable reset vector, an exception
// redirect vector and a circular return-address stack (RAS). The RAS predicts
// the target of `jr $ra` in fetch.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   En         fetch enable; 0 holds the PC and leaves the RAS untouched
//   ExcReq     exception redirect (wins even while stalled)
//   PCSrcD     decode-stage taken branch, target PCBranchD
//   Jump       fetch-stage j/jal, target PCJumpF
//   Call       qualifies Jump as jal (pushes the return address)
//   Ret        fetch-stage `jr $ra`, predicted from the RAS
//   PCF        current fetch PC
//   PCPlus4F   PCF + 4, registered alongside PCF
//   RasTop     top-of-stack entry, 0 when the stack is empty
//   RasEmpty   stack holds no valid entries
//   RasFull    stack holds RAS_DEPTH valid entries
// ---------------------------------------------------------------------------
module pc_ras_unit #(
  parameter int unsigned ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = 32'h00003000,
  parameter logic [ADDR_W-1:0] EXC_VECTOR   = 32'h00004180,
  parameter int unsigned RAS_DEPTH    = 4,
  parameter int unsigned RAS_PTR_W    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              En,
  input  logic              ExcReq,
  input  logic              PCSrcD,
  input  logic [ADDR_W-1:0] PCBranchD,
  input  logic              Jump,
  input  logic [ADDR_W-1:0] PCJumpF,
  input  logic              Call,
  input  logic              Ret,
  output logic [ADDR_W-1:0] PCF,
  output logic [ADDR_W-1:0] PCPlus4F,
  output logic [ADDR_W-1:0] RasTop,
  output logic              RasEmpty,
  output logic              RasFull
);

  localparam logic [RAS_PTR_W:0] FULL_COUNT = (RAS_PTR_W+1)'(RAS_DEPTH);

  logic [ADDR_W-1:0]    pc_reg;
  logic [ADDR_W-1:0]    pc_plus4_reg;
  logic [ADDR_W-1:0]    ras_mem [RAS_DEPTH];
  logic [RAS_PTR_W-1:0] ras_ptr;
  logic [RAS_PTR_W:0]   ras_count;

  logic [ADDR_W-1:0]    next_pc;
  logic                 pc_load;
  logic                 ras_push;
  logic                 ras_pop;
  logic                 ras_flush;
  logic [RAS_PTR_W-1:0] ptr_inc;
  logic [RAS_PTR_W-1:0] ptr_dec;

  assign ptr_inc = ras_ptr + RAS_PTR_W'(1);
  assign ptr_dec = ras_ptr - RAS_PTR_W'(1);

  assign PCF      = pc_reg;
  assign PCPlus4F = pc_plus4_reg;
  assign RasEmpty = (ras_count == '0);
  assign RasFull  = (ras_count == FULL_COUNT);
  assign RasTop   = RasEmpty ? '0 : ras_mem[ras_ptr];

  // Redirect selection in priority order; at most one RAS operation results.
  always_comb begin
    next_pc   = pc_plus4_reg;
    pc_load   = 1'b1;
    ras_push  = 1'b0;
    ras_pop   = 1'b0;
    ras_flush = 1'b0;
    if (ExcReq) begin
      next_pc   = EXC_VECTOR;
      ras_flush = 1'b1;
    end else if (!En) begin
      pc_load = 1'b0;
    end else if (PCSrcD) begin
      next_pc = PCBranchD;
    end else if (Jump) begin
      next_pc  = PCJumpF;
      ras_push = Call;
    end else if (Ret && !RasEmpty) begin
      next_pc = RasTop;
      ras_pop = 1'b1;
    end
  end

  // PC and PC+4 are loaded together so they never skew by a cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_reg       <= RESET_VECTOR;
      pc_plus4_reg <= RESET_VECTOR + ADDR_W'(4);
    end else if (pc_load) begin
      pc_reg       <= next_pc;
      pc_plus4_reg <= next_pc + ADDR_W'(4);
    end
  end

  // Circular stack: a push when full overwrites the oldest slot, which is
  // exactly the slot after the top pointer, so the count simply saturates.
  // A flush only clears the count; stale entries are hidden by RasTop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ras_ptr   <= '0;
      ras_count <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_mem[i] <= '0;
      end
    end else if (ras_flush) begin
      ras_count <= '0;
    end else if (ras_push) begin
      ras_ptr          <= ptr_inc;
      ras_mem[ptr_inc] <= pc_plus4_reg;
      if (ras_count != FULL_COUNT) begin
        ras_count <= ras_count + (RAS_PTR_W+1)'(1);
      end
    end else if (ras_pop) begin
      ras_ptr   <= ptr_dec;
      ras_count <= ras_count - (RAS_PTR_W+1)'(1);
    end
  end

endmodule
